muldiv_exec_unit: RTL and testbench
===================================

Name: muldiv_exec_unit

Overview:
- Iterative, parametrised RV32M/RV64M multiply/divide execution unit, instantiated in EX alongside the combinational ALU path.
- Accepts already-forwarded operands through a valid/ready handshake. While it is busy it holds the pipeline via stall_req.
- Returns the result with its rd address over a second valid/ready handshake.
- Supports a synchronous flush for branch, interrupt and trap redirects.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- BITS_PER_CYCLE, 1, radix of the iterative engine; must be 1, 2 or 4 and divide XLEN.
- FAST_ZERO, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept; high only in IDLE
- in_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_rs1  input  XLEN  forwarded rs1 value
- in_rs2  input  XLEN  forwarded rs2 value
- in_rd_addr  input  5  destination register
- flush  input  1  abort any in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_result  output  XLEN  result
- out_rd_addr  output  5  destination of result
- busy  output  1  state != IDLE
- stall_req  output  1  busy OR (in_valid AND NOT in_ready)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, out_result=0, out_rd_addr=0, iteration counter=0, internal operand registers=0.
- States: IDLE, CALC, FIN, DONE. Define N = XLEN/BITS_PER_CYCLE.
- IDLE:
  - in_ready=1. The request is accepted on an edge where in_valid=1 and flush=0.
  - On accept, latch op, rd_addr, operand magnitudes and result sign.
  - Signedness by op: MULH treats both operands as signed; MULHSU treats rs1 signed, rs2 unsigned; DIV/REM are signed; all others are unsigned.
  - Special case, FAST_ZERO=1, with either (a) divisor=0 or (b) signed op with rs1=most-negative and rs2=all-ones: load the final result directly and go to DONE.
  - Otherwise load counter=N and go to CALC.
- CALC:
  - Each cycle retires BITS_PER_CYCLE bits: shift-add for multiply, restoring shift-subtract for divide.
  - Counter decrements each cycle; when it reaches 0, go to FIN. CALC lasts exactly N cycles.
- FIN:
  - Apply two's-complement sign correction.
  - Select the result: low XLEN bits of the 2*XLEN product for MUL, high XLEN bits for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Remainder takes the sign of the dividend.
  - Register out_result and out_rd_addr, then go to DONE.
- DONE:
  - out_valid=1; out_result and out_rd_addr held stable until out_ready=1.
  - On out_valid and out_ready, go to IDLE. No new accept occurs in the same cycle (in_ready=0 in DONE).
- Latency, counted from the accept edge to the first edge with out_valid=1:
  - Normal path: N+2 cycles (34 at the defaults).
  - Fast path: 1 cycle.
- Special results, which are identical on the iterative path when FAST_ZERO=0:
  - DIV or DIVU by 0: all-ones.
  - REM or REMU by 0: rs1.
  - DIV overflow: most-negative value.
  - REM overflow: 0.
- Flush:
  - Synchronous; takes priority over every other event.
  - From any state, go to IDLE on the next edge; out_valid drops on that same edge and the result is discarded.
  - A request presented in the same cycle as flush is not accepted.
- in_valid deasserting after accept has no effect. Operands are only sampled on the accept edge.
- Reset asserted mid-operation returns the unit to the reset state immediately. No output is produced for the aborted operation.

Test Plan:
- Multiply with latency check: MUL 7 × 0xFFFFFFFD (−3) → out_result=0xFFFFFFEB. out_valid rises exactly 34 cycles after accept. busy and stall_req are high throughout.
- High-half multiplies: MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide: DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
- Special cases with FAST_ZERO=1, each with out_valid one cycle after accept:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. out_result and out_rd_addr stay stable, in_ready=0, and release happens on the out_ready edge.
- Flush and reset mid-operation:
  - Flush on the 10th CALC cycle: out_valid never asserts and in_ready=1 next cycle. A following DIVU 100/7 returns 14.
  - rst_n pulsed mid-CALC: all outputs return to 0 asynchronously.
  - With BITS_PER_CYCLE=4, MUL latency is 10 cycles.

Source files
------------

// File: rtl/muldiv_exec_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Radix-2^BITS_PER_CYCLE shift-add multiply and restoring divide, valid/ready on both sides.
module muldiv_exec_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter bit FAST_ZERO      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd_addr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd_addr,
    output logic            busy,
    output logic            stall_req
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic                neg_q, neg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [4:0]          res_rd_q, res_rd_d;

    logic                rs1_signed, rs2_signed, a_neg, b_neg;
    logic                div_op, div_zero, div_ovf, take_fast, sign_in;
    logic [XLEN-1:0]     a_mag, b_mag, fast_result;

    // Operand decode at accept: magnitudes, final result sign and the shortcut cases.
    always_comb begin
        rs1_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        rs2_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        a_neg      = rs1_signed && in_rs1[XLEN-1];
        b_neg      = rs2_signed && in_rs2[XLEN-1];
        a_mag      = a_neg ? -in_rs1 : in_rs1;
        b_mag      = b_neg ? -in_rs2 : in_rs2;
        div_op     = in_op[2];
        div_zero   = div_op && (in_rs2 == '0);
        div_ovf    = div_op && !in_op[0] && (in_rs1 == MOST_NEG) && (in_rs2 == '1);
        take_fast  = FAST_ZERO && (div_zero || div_ovf);
        if (div_zero) begin
            fast_result = in_op[1] ? in_rs1 : '1;
        end else begin
            fast_result = in_op[1] ? '0 : MOST_NEG;
        end
        // A zero divisor must leave the all-ones quotient un-negated.
        if (div_op) begin
            sign_in = in_op[1] ? a_neg : ((a_neg ^ b_neg) && (in_rs2 != '0));
        end else begin
            sign_in = a_neg ^ b_neg;
        end
    end

    logic [2*XLEN:0]   mul_t;
    logic [XLEN:0]     rem_t;
    logic [XLEN-1:0]   quo_t;
    logic [2*XLEN-1:0] step_prod;

    // One CALC cycle: BITS_PER_CYCLE radix-2 steps; prod_q holds {acc/remainder, multiplier/quotient}.
    always_comb begin
        mul_t = {1'b0, prod_q};
        rem_t = {1'b0, prod_q[2*XLEN-1:XLEN]};
        quo_t = prod_q[XLEN-1:0];
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mul_t[0]) begin
                mul_t[2*XLEN:XLEN] = mul_t[2*XLEN:XLEN] + {1'b0, mcand_q};
            end
            mul_t = mul_t >> 1;
            rem_t = {rem_t[XLEN-1:0], quo_t[XLEN-1]};
            quo_t = {quo_t[XLEN-2:0], 1'b0};
            if (rem_t >= {1'b0, mcand_q}) begin
                rem_t    = rem_t - {1'b0, mcand_q};
                quo_t[0] = 1'b1;
            end
        end
        step_prod = op_q[2] ? {rem_t[XLEN-1:0], quo_t} : mul_t[2*XLEN-1:0];
    end

    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_s, rem_s, fin_result;

    always_comb begin
        prod_signed = neg_q ? -prod_q : prod_q;
        quo_s       = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem_s       = neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:                fin_result = prod_signed[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fin_result = prod_signed[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fin_result = quo_s;
            default:             fin_result = rem_s;
        endcase
    end

    // Next-state logic; flush overrides everything and blocks any accept.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_rd_d = res_rd_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d    = in_op;
                        rd_d    = in_rd_addr;
                        neg_d   = sign_in;
                        mcand_d = div_op ? b_mag : a_mag;
                        prod_d  = {{XLEN{1'b0}}, (div_op ? a_mag : b_mag)};
                        if (take_fast) begin
                            res_d    = fast_result;
                            res_rd_d = in_rd_addr;
                            state_d  = DONE;
                        end else begin
                            cnt_d   = CW'(N);
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    prod_d = step_prod;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = FIN;
                    end
                end
                FIN: begin
                    res_d    = fin_result;
                    res_rd_d = rd_q;
                    state_d  = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_rd_q <= res_rd_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign stall_req   = busy || (in_valid && !in_ready);
    assign out_result  = res_q;
    assign out_rd_addr = res_rd_q;

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Self-checking bench for muldiv_exec_unit: a radix-2 fast-zero unit and a radix-16 unit
// without the fast path, both checked against an arithmetic reference model.
module tb_muldiv_exec_unit;

    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1, out_ready4 = 1'b1;
    logic [2:0]  in_op = '0;
    logic [31:0] in_rs1 = '0, in_rs2 = '0;
    logic [4:0]  in_rd_addr = '0;

    logic        in_ready, out_valid, busy, stall_req;
    logic [31:0] out_result;
    logic [4:0]  out_rd_addr;
    logic        in_ready4, out_valid4, busy4, stall_req4;
    logic [31:0] out_result4;
    logic [4:0]  out_rd_addr4;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    muldiv_exec_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .FAST_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_addr(in_rd_addr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd_addr(out_rd_addr), .busy(busy), .stall_req(stall_req)
    );

    muldiv_exec_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .FAST_ZERO(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_addr(in_rd_addr),
        .flush(flush), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_result(out_result4), .out_rd_addr(out_rd_addr4), .busy(busy4), .stall_req(stall_req4)
    );

    // Reference: RISC-V M-extension semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return MOST_NEG;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op[2] && b == 32'd0) ||
               ((op == 3'd4 || op == 3'd6) && a == MOST_NEG && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MOST_NEG;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request to either unit and wait (bounded) for its result, then release it.
    task automatic run_op(input bit sel4, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output bit busy_ok);
        @(posedge clk); #1;
        in_op = op; in_rs1 = a; in_rs2 = b; in_rd_addr = rd;
        if (sel4) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid4 = 1'b0;
        in_op = 3'($urandom); in_rs1 = $urandom; in_rs2 = $urandom; in_rd_addr = 5'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!(sel4 ? out_valid4 : out_valid) && lat < 100) begin
            if (sel4 ? !(busy4 && stall_req4) : !(busy && stall_req)) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = sel4 ? out_result4 : out_result;
        rdo = sel4 ? out_rd_addr4 : out_rd_addr;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_result !== 32'd0) $display("[TB] FAIL reset_out_result: got %h expected 0", out_result); else passed++;
        checks++; if (out_rd_addr !== 5'd0) $display("[TB] FAIL reset_out_rd: got %h expected 0", out_rd_addr); else passed++;
        checks++; if (busy !== 1'b0 || stall_req !== 1'b0) $display("[TB] FAIL reset_busy: got %b/%b expected 0/0", busy, stall_req); else passed++;
        checks++; if (in_ready !== 1'b1 || in_ready4 !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, in_ready4); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_mul_latency();
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        run_op(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, r, d, lat, bok);
        checks++; if (r !== 32'hFFFF_FFEB) $display("[TB] FAIL mul_result: got %h expected ffffffeb", r); else passed++;
        checks++; if (d !== 5'd5) $display("[TB] FAIL mul_rd: got %0d expected 5", d); else passed++;
        checks++; if (lat != 34) $display("[TB] FAIL mul_latency: got %0d expected 34", lat); else passed++;
        checks++; if (!bok) $display("[TB] FAIL mul_busy_stall: got low during op expected high"); else passed++;
    endtask

    task automatic test_high_mul();
        logic [2:0]  ops [3] = '{3'd1, 3'd2, 3'd3};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, ops[i], as[i], bs[i], 5'(i + 1), r, d, lat, bok);
            checks++; if (r !== exp[i]) $display("[TB] FAIL high_mul_%0d: got %h expected %h", ops[i], r, exp[i]); else passed++;
        end
    endtask

    task automatic test_signed_div();
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        run_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, r, d, lat, bok);
        checks++; if (r !== 32'hFFFF_FFFD) $display("[TB] FAIL div_neg7_2: got %h expected fffffffd", r); else passed++;
        run_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, r, d, lat, bok);
        checks++; if (r !== 32'hFFFF_FFFF) $display("[TB] FAIL rem_neg7_2: got %h expected ffffffff", r); else passed++;
    endtask

    task automatic test_fast_special();
        logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'd5, 32'd5, MOST_NEG, MOST_NEG};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, MOST_NEG, 32'd0};
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, ops[i], as[i], bs[i], 5'(20 + i), r, d, lat, bok);
            checks++; if (r !== exp[i]) $display("[TB] FAIL fast_result_%0d: got %h expected %h", i, r, exp[i]); else passed++;
            checks++; if (lat != 1) $display("[TB] FAIL fast_latency_%0d: got %0d expected 1", i, lat); else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r0; logic [4:0] d0; int lat; bit stable_ok;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_op = 3'd3; in_rs1 = 32'h1234_5678; in_rs2 = 32'h9ABC_DEF0; in_rd_addr = 5'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        r0 = out_result; d0 = out_rd_addr;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_result !== r0 || out_rd_addr !== d0 || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        checks++; if (r0 !== ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0) || d0 !== 5'd17)
            $display("[TB] FAIL bp_result: got %h/%0d expected %h/17", r0, d0, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0)); else passed++;
        checks++; if (!stable_ok) $display("[TB] FAIL bp_hold: got unstable or in_ready high expected stable hold"); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_flush();
        logic [31:0] r; logic [4:0] d; int lat; bit bok; bit seen;
        @(posedge clk); #1;
        in_op = 3'd0; in_rs1 = 32'd3; in_rs2 = 32'd4; in_rd_addr = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL flush_idle: got ready=%b busy=%b expected 1/0", in_ready, busy); else passed++;
        seen = 1'b0;
        repeat (40) begin if (out_valid) seen = 1'b1; @(posedge clk); #1; end
        checks++; if (seen) $display("[TB] FAIL flush_no_output: got out_valid=1 expected 0"); else passed++;
        run_op(1'b0, 3'd5, 32'd100, 32'd7, 5'd12, r, d, lat, bok);
        checks++; if (r !== 32'd14 || d !== 5'd12) $display("[TB] FAIL flush_next_divu: got %0d/%0d expected 14/12", r, d); else passed++;
        @(posedge clk); #1;
        in_op = 3'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL flush_blocks_accept: got busy=%b expected 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_calc();
        bit seen;
        @(posedge clk); #1;
        in_op = 3'd1; in_rs1 = 32'hDEAD_BEEF; in_rs2 = 32'h0BAD_F00D; in_rd_addr = 5'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd_addr !== 5'd0)
            $display("[TB] FAIL rst_mid_outputs: got %b/%h/%0d expected 0/0/0", out_valid, out_result, out_rd_addr); else passed++;
        checks++; if (busy !== 1'b0 || stall_req !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b/%b expected 0/0", busy, stall_req); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin if (out_valid) seen = 1'b1; @(posedge clk); #1; end
        checks++; if (seen) $display("[TB] FAIL rst_mid_no_output: got out_valid=1 expected 0"); else passed++;
    endtask

    task automatic test_radix4();
        logic [2:0]  ops [6] = '{3'd0, 3'd4, 3'd6, 3'd4, 3'd6, 3'd7};
        logic [31:0] as  [6] = '{32'd7, 32'd5, 32'hFFFF_FFF9, MOST_NEG, MOST_NEG, 32'd9};
        logic [31:0] bs  [6] = '{32'hFFFF_FFFD, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        for (int i = 0; i < 6; i++) begin
            run_op(1'b1, ops[i], as[i], bs[i], 5'(i), r, d, lat, bok);
            checks++; if (r !== ref_model(ops[i], as[i], bs[i])) $display("[TB] FAIL r4_result_%0d: got %h expected %h", i, r, ref_model(ops[i], as[i], bs[i])); else passed++;
            checks++; if (lat != 10) $display("[TB] FAIL r4_latency_%0d: got %0d expected 10", i, lat); else passed++;
        end
        for (int i = 0; i < 10; i++) begin
            logic [2:0] op; logic [31:0] a, b;
            op = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand();
            run_op(1'b1, op, a, b, 5'(i), r, d, lat, bok);
            checks++; if (r !== ref_model(op, a, b)) $display("[TB] FAIL r4_rand_op%0d: got %h expected %h", op, r, ref_model(op, a, b)); else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op; logic [31:0] a, b; logic [4:0] rd; int exp_lat;
            op = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
            exp_lat = is_fast(op, a, b) ? 1 : 34;
            run_op(1'b0, op, a, b, rd, r, d, lat, bok);
            checks++; if (r !== ref_model(op, a, b)) $display("[TB] FAIL rand_op%0d %h %h: got %h expected %h", op, a, b, r, ref_model(op, a, b)); else passed++;
            checks++; if (d !== rd) $display("[TB] FAIL rand_rd: got %0d expected %0d", d, rd); else passed++;
            checks++; if (lat != exp_lat) $display("[TB] FAIL rand_latency_op%0d: got %0d expected %0d", op, lat, exp_lat); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_high_mul();
        test_signed_div();
        test_fast_special();
        test_backpressure();
        test_flush();
        test_reset_mid_calc();
        test_radix4();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
